x1_ioctl_loader: RTL and testbench

X1_IOCTL_LOADER -- requirements
Module: x1_ioctl_loader

---
 rtl/x1_ioctl_loader.sv | 132 +++++++++++++
 tb/tb_x1_ioctl_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x1_ioctl_loader.sv
// HPS ioctl download loader: routes byte strobes to IPL, CG or RAM targets with a
// one-deep request/ack handshake, per-window byte count, checksum and sticky error flags.
module x1_ioctl_loader #(
    parameter int IPL_SIZE = 4096,
    parameter int CG_SIZE  = 2048,
    parameter int RAM_SIZE = 65536
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [1:0]  mem_sel,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        load_done,
    output logic [16:0] byte_count,
    output logic [7:0]  checksum,
    output logic        err_range,
    output logic        err_index,
    output logic        err_proto
);
    typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

    state_t      state;
    logic        dl_q;
    logic        fall_pend;   // window closed while a write was outstanding
    logic        stale;       // outstanding write belongs to a window already replaced
    logic [31:0] lim;
    logic        idx_ok;
    logic        in_range;
    logic        wr_en;
    logic        rise;
    logic        fall;

    assign rise     = ioctl_download & ~dl_q;
    assign fall     = ~ioctl_download & dl_q;
    assign wr_en    = ioctl_wr & ioctl_download;
    assign in_range = ({7'd0, ioctl_addr} < lim);

    always_comb begin
        lim    = 32'd0;
        idx_ok = 1'b1;
        case (ioctl_index)
            8'd0:    lim = 32'(IPL_SIZE);
            8'd1:    lim = 32'(CG_SIZE);
            8'd2:    lim = 32'(RAM_SIZE);
            default: idx_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            fall_pend  <= 1'b0;
            stale      <= 1'b0;
            ioctl_wait <= 1'b0;
            mem_req    <= 1'b0;
            mem_sel    <= 2'd0;
            mem_addr   <= 16'd0;
            mem_data   <= 8'd0;
            load_done  <= 1'b0;
            byte_count <= 17'd0;
            checksum   <= 8'd0;
            err_range  <= 1'b0;
            err_index  <= 1'b0;
            err_proto  <= 1'b0;
        end else begin
            dl_q      <= ioctl_download;
            load_done <= 1'b0;
            // Window start clears first; an error raised on the same edge still sticks.
            if (rise) begin
                byte_count <= 17'd0;
                checksum   <= 8'd0;
                err_range  <= 1'b0;
                err_index  <= 1'b0;
                err_proto  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (fall) load_done <= 1'b1;
                    if (wr_en) begin
                        if (!idx_ok) begin
                            err_index <= 1'b1;
                        end else if (!in_range) begin
                            err_range <= 1'b1;
                        end else begin
                            mem_sel    <= ioctl_index[1:0];
                            mem_addr   <= ioctl_addr[15:0];
                            mem_data   <= ioctl_dout;
                            mem_req    <= 1'b1;
                            ioctl_wait <= 1'b1;
                            fall_pend  <= 1'b0;
                            stale      <= 1'b0;
                            state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (wr_en) err_proto <= 1'b1;
                    if (fall) fall_pend <= 1'b1;
                    if (rise) begin
                        stale     <= 1'b1;
                        fall_pend <= 1'b0;
                    end
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        ioctl_wait <= 1'b0;
                        if (!stale && !rise) begin
                            byte_count <= (byte_count == 17'h1FFFF) ? byte_count
                                                                    : byte_count + 17'd1;
                            checksum   <= checksum + mem_data;
                        end
                        state <= ((fall_pend || fall) && !rise) ? FLUSH : IDLE;
                    end
                end
                FLUSH: begin
                    if (wr_en) err_proto <= 1'b1;
                    load_done <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_x1_ioctl_loader.sv
// Bench for x1_ioctl_loader: randomized strobes against a queue-based model of which
// bytes reach which target, plus directed window, flush, protocol and reset scenarios.
module tb_x1_ioctl_loader;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        mem_ack = 1'b0;
    logic        ioctl_wait, mem_req, load_done, err_range, err_index, err_proto;
    logic [1:0]  mem_sel;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data, checksum;
    logic [16:0] byte_count;

    x1_ioctl_loader dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_data(mem_data),
        .load_done(load_done), .byte_count(byte_count), .checksum(checksum),
        .err_range(err_range), .err_index(err_index), .err_proto(err_proto)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the target memories should have seen this window.
    logic [25:0] exp_q[$];
    logic [25:0] obs_q[$];
    int          m_cnt;
    logic [7:0]  m_sum;
    bit          m_er, m_ei;

    function automatic int cap(input logic [7:0] idx);
        case (idx)
            8'd0:    return 4096;
            8'd1:    return 2048;
            8'd2:    return 65536;
            default: return 0;
        endcase
    endfunction

    task automatic model_window_start();
        m_cnt = 0; m_sum = 8'd0; m_er = 0; m_ei = 0;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic model_wr(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] d);
        if (cap(idx) == 0) m_ei = 1;
        else if (int'(addr) >= cap(idx)) m_er = 1;
        else begin
            exp_q.push_back({idx[1:0], addr[15:0], d});
            if (m_cnt < 131071) m_cnt++;
            m_sum = m_sum + d;
        end
    endtask

    // Memory responder and activity monitor.
    int          ack_dly = 3;
    bit          ack_tie = 0, ack_force = 0;
    int          unstable = 0, wrun = 0, max_wrun = 0, ld_cnt = 0, req_rises = 0;
    int          cyc_n = 0, ld_cyc = 0, req_fall_cyc = 0;
    initial begin
        int cnt = 0;
        bit prev_req = 0;
        logic [25:0] prev_val = '0;
        forever begin
            @(posedge clk_sys); #1;
            cyc_n++;
            if (mem_req && prev_req && {mem_sel, mem_addr, mem_data} !== prev_val) unstable++;
            if (mem_req && !prev_req) req_rises++;
            if (!mem_req && prev_req) req_fall_cyc = cyc_n;
            if (load_done) begin ld_cnt++; ld_cyc = cyc_n; end
            if (ioctl_wait) begin wrun++; if (wrun > max_wrun) max_wrun = wrun; end
            else wrun = 0;
            if (ack_force || ack_tie) mem_ack = 1'b1;
            else if (mem_req && !mem_ack) begin
                cnt++;
                if (cnt >= ack_dly) begin mem_ack = 1'b1; cnt = 0; end
            end else begin
                mem_ack = 1'b0; cnt = 0;
            end
            if (mem_req && mem_ack) obs_q.push_back({mem_sel, mem_addr, mem_data});
            prev_req = mem_req;
            prev_val = {mem_sel, mem_addr, mem_data};
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk_sys); #1; end
    endtask

    task automatic strobe(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] d);
        int t = 0;
        ioctl_index = idx; ioctl_addr = addr; ioctl_dout = d; ioctl_wr = 1'b1;
        cyc(1);
        ioctl_wr = 1'b0;
        if (ioctl_download) model_wr(idx, addr, d);
        while (ioctl_wait && t < 200) begin cyc(1); t++; end
        if (t >= 200) begin n_tests++; n_fail++; $display("FAIL strobe_timeout: wait still high"); end
    endtask

    task automatic win_start();
        model_window_start();
        ioctl_download = 1'b1;
        cyc(2);
    endtask

    task automatic test_reset();
        cyc(2);
        n_tests++;
        if ({mem_req, ioctl_wait, load_done, mem_sel, mem_addr, mem_data, byte_count,
             checksum, err_range, err_index, err_proto} !== '0) begin
            n_fail++; $display("FAIL reset_held: outputs not all zero");
        end
        reset_n = 1'b1;
        cyc(2);
        n_tests++;
        if ({mem_req, ioctl_wait, load_done, byte_count, checksum, err_range, err_index,
             err_proto} !== '0) begin
            n_fail++; $display("FAIL reset_release: outputs not all zero");
        end
    endtask

    task automatic test_ipl_basic();
        bit bad;
        ack_dly = 3;
        win_start();
        strobe(8'd0, 25'd0, 8'h11);
        strobe(8'd0, 25'd1, 8'h22);
        strobe(8'd0, 25'd2, 8'h33);
        ld_cnt = 0;
        ioctl_download = 1'b0;
        cyc(4);
        bad = (obs_q.size() != 3);
        foreach (exp_q[i]) if (!bad && obs_q[i] !== exp_q[i]) bad = 1;
        n_tests++; if (bad) begin n_fail++; $display("FAIL ipl_writes: got %0d writes want 3", obs_q.size()); end
        n_tests++; if (byte_count !== 17'd3) begin n_fail++; $display("FAIL ipl_count: got %0d want 3", byte_count); end
        n_tests++; if (checksum !== 8'h66) begin n_fail++; $display("FAIL ipl_sum: got %0h want 66", checksum); end
        n_tests++; if (ld_cnt !== 1) begin n_fail++; $display("FAIL ipl_done: got %0d pulses want 1", ld_cnt); end
    endtask

    task automatic test_cg_range();
        bit bad;
        win_start();
        strobe(8'd1, 25'd2047, 8'($urandom));
        strobe(8'd1, 25'd2048, 8'($urandom));
        cyc(3);
        bad = (obs_q.size() != 1) || (exp_q.size() != 1);
        if (!bad && (obs_q[0] !== exp_q[0] || obs_q[0][23:8] !== 16'h07FF)) bad = 1;
        n_tests++; if (bad) begin n_fail++; $display("FAIL cg_writes: got %0d writes want 1 at 7ff", obs_q.size()); end
        n_tests++; if (err_range !== 1'b1) begin n_fail++; $display("FAIL cg_err_range: got %0b want 1", err_range); end
        n_tests++; if (byte_count !== 17'd1) begin n_fail++; $display("FAIL cg_count: got %0d want 1", byte_count); end
        n_tests++; if (err_index !== 1'b0) begin n_fail++; $display("FAIL cg_err_index: got %0b want 0", err_index); end
        ioctl_download = 1'b0; cyc(2);
    endtask

    task automatic test_bad_index();
        int r0;
        ack_dly = 1;
        win_start();
        r0 = req_rises;
        repeat (10) strobe(8'd5, 25'($urandom_range(0, 100)), 8'($urandom));
        ld_cnt = 0;
        ioctl_download = 1'b0;
        cyc(3);
        n_tests++; if (req_rises !== r0) begin n_fail++; $display("FAIL badidx_req: got %0d requests want 0", req_rises - r0); end
        n_tests++; if (err_index !== 1'b1) begin n_fail++; $display("FAIL badidx_err: got %0b want 1", err_index); end
        n_tests++; if (byte_count !== 17'd0) begin n_fail++; $display("FAIL badidx_count: got %0d want 0", byte_count); end
        n_tests++; if (ld_cnt !== 1) begin n_fail++; $display("FAIL badidx_done: got %0d pulses want 1", ld_cnt); end
    endtask

    task automatic test_flush();
        int t = 0;
        ack_dly = 5;
        win_start();
        ioctl_index = 8'd2; ioctl_addr = 25'($urandom_range(0, 65535)); ioctl_dout = 8'($urandom);
        ioctl_wr = 1'b1;
        cyc(1);
        ioctl_wr = 1'b0;
        model_wr(ioctl_index, ioctl_addr, ioctl_dout);
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL flush_latency: mem_req %0b want 1", mem_req); end
        ld_cnt = 0;
        ioctl_download = 1'b0;
        while (mem_req && t < 50) begin cyc(1); t++; end
        cyc(3);
        n_tests++; if (ld_cnt !== 1) begin n_fail++; $display("FAIL flush_done: got %0d pulses want 1", ld_cnt); end
        n_tests++; if (ld_cyc !== req_fall_cyc + 1) begin n_fail++; $display("FAIL flush_timing: done at %0d want %0d", ld_cyc, req_fall_cyc + 1); end
        n_tests++; if (byte_count !== 17'd1) begin n_fail++; $display("FAIL flush_count: got %0d want 1", byte_count); end
        n_tests++; if (checksum !== m_sum) begin n_fail++; $display("FAIL flush_sum: got %0h want %0h", checksum, m_sum); end
    endtask

    task automatic test_proto_reset();
        logic [24:0] a;
        logic [7:0]  d;
        int t = 0;
        bit bad;
        ack_dly = 6;
        win_start();
        unstable = 0;
        a = 25'($urandom_range(0, 65535)); d = 8'($urandom);
        ioctl_index = 8'd2; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
        cyc(1);
        model_wr(8'd2, a, d);
        ioctl_addr = a ^ 25'h155; ioctl_dout = ~d;
        cyc(1);
        ioctl_wr = 1'b0;
        n_tests++; if (err_proto !== 1'b1) begin n_fail++; $display("FAIL proto_err: got %0b want 1", err_proto); end
        n_tests++; if (mem_addr !== a[15:0] || mem_data !== d) begin
            n_fail++; $display("FAIL proto_hold: got %0h/%0h want %0h/%0h", mem_addr, mem_data, a[15:0], d);
        end
        while (ioctl_wait && t < 50) begin cyc(1); t++; end
        cyc(2);
        bad = (obs_q.size() != 1) || (exp_q.size() != 1);
        if (!bad && obs_q[0] !== exp_q[0]) bad = 1;
        n_tests++; if (bad || unstable != 0) begin n_fail++; $display("FAIL proto_write: got %0d writes, %0d unstable", obs_q.size(), unstable); end
        n_tests++; if (byte_count !== 17'd1) begin n_fail++; $display("FAIL proto_count: got %0d want 1", byte_count); end

        ack_dly = 20;
        ioctl_addr = 25'd7; ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
        cyc(1);
        ioctl_wr = 1'b0;
        cyc(1);
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (mem_req !== 1'b0 || ioctl_wait !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: mem_req %0b wait %0b want 0", mem_req, ioctl_wait);
        end
        n_tests++; if ({byte_count, checksum, err_proto} !== '0) begin
            n_fail++; $display("FAIL reset_clear: count %0d sum %0h proto %0b want 0", byte_count, checksum, err_proto);
        end
        cyc(1);
        model_window_start();
        reset_n = 1'b1;
        cyc(2);
        ack_force = 1'b1; cyc(1); ack_force = 1'b0;
        cyc(3);
        n_tests++; if (byte_count !== 17'd0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL stray_ack: count %0d req %0b want 0", byte_count, mem_req);
        end
        ack_dly = 2;
        strobe(8'd0, 25'd9, 8'h3C);
        cyc(2);
        n_tests++; if (byte_count !== 17'd1 || checksum !== 8'h3C || obs_q.size() != 1) begin
            n_fail++; $display("FAIL post_reset: count %0d sum %0h want 1/3c", byte_count, checksum);
        end
        ioctl_download = 1'b0; cyc(2);
    endtask

    task automatic test_ram_stream();
        bit bad;
        win_start();
        ack_tie = 1;
        max_wrun = 0;
        for (int i = 0; i < 256; i++) strobe(8'd2, 25'($urandom_range(0, 65535)), 8'hFF);
        ack_tie = 0;
        cyc(2);
        bad = (obs_q.size() != exp_q.size());
        foreach (exp_q[i]) if (!bad && obs_q[i] !== exp_q[i]) bad = 1;
        n_tests++; if (bad) begin n_fail++; $display("FAIL ram_writes: got %0d want %0d", obs_q.size(), exp_q.size()); end
        n_tests++; if (byte_count !== 17'd256) begin n_fail++; $display("FAIL ram_count: got %0d want 256", byte_count); end
        n_tests++; if (checksum !== 8'h00) begin n_fail++; $display("FAIL ram_sum: got %0h want 00", checksum); end
        n_tests++; if (max_wrun > 1) begin n_fail++; $display("FAIL ram_wait: run %0d want <=1", max_wrun); end
        ioctl_download = 1'b0; cyc(2);
    endtask

    task automatic test_random();
        bit bad;
        logic [7:0]  idx;
        logic [24:0] addr;
        int c;
        win_start();
        for (int i = 0; i < 80; i++) begin
            idx = 8'($urandom_range(0, 3));
            c = cap(idx);
            ack_dly = $urandom_range(1, 4);
            case ($urandom_range(0, 3))
                0: addr = (c > 0) ? 25'($urandom_range(0, c - 1)) : 25'($urandom);
                1: addr = (c > 0) ? 25'(c - 1) : 25'($urandom);
                2: addr = 25'(c);
                default: addr = 25'($urandom);
            endcase
            strobe(idx, addr, 8'($urandom));
        end
        cyc(3);
        bad = (obs_q.size() != exp_q.size());
        foreach (exp_q[i]) if (!bad && obs_q[i] !== exp_q[i]) bad = 1;
        n_tests++; if (bad) begin n_fail++; $display("FAIL rnd_writes: got %0d want %0d", obs_q.size(), exp_q.size()); end
        n_tests++; if (byte_count !== 17'(m_cnt)) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", byte_count, m_cnt); end
        n_tests++; if (checksum !== m_sum) begin n_fail++; $display("FAIL rnd_sum: got %0h want %0h", checksum, m_sum); end
        n_tests++; if (err_range !== m_er || err_index !== m_ei || err_proto !== 1'b0) begin
            n_fail++; $display("FAIL rnd_errs: got %0b%0b%0b want %0b%0b0", err_range, err_index, err_proto, m_er, m_ei);
        end
        ioctl_download = 1'b0;
        cyc(2);
    endtask

    task automatic test_hold_no_download();
        int r0 = req_rises;
        cyc(5);
        strobe(8'd0, 25'd0, 8'hA5);
        strobe(8'd7, 25'd3, 8'h5A);
        cyc(3);
        n_tests++; if (req_rises !== r0) begin n_fail++; $display("FAIL nodl_req: got %0d requests want 0", req_rises - r0); end
        n_tests++; if (byte_count !== 17'(m_cnt) || checksum !== m_sum) begin
            n_fail++; $display("FAIL hold_counts: got %0d/%0h want %0d/%0h", byte_count, checksum, m_cnt, m_sum);
        end
        n_tests++; if (err_range !== m_er || err_index !== m_ei || err_proto !== 1'b0) begin
            n_fail++; $display("FAIL hold_errs: got %0b%0b%0b want %0b%0b0", err_range, err_index, err_proto, m_er, m_ei);
        end
    endtask

    task automatic test_window_clear();
        strobe(8'd9, 25'd0, 8'h00);
        ioctl_download = 1'b1;
        strobe(8'd9, 25'd0, 8'h00);
        ioctl_download = 1'b0; cyc(2);
        model_window_start();
        ioctl_download = 1'b1;
        cyc(2);
        n_tests++; if ({byte_count, checksum, err_range, err_index, err_proto} !== '0) begin
            n_fail++; $display("FAIL window_clear: count %0d sum %0h errs %0b%0b%0b want 0", byte_count, checksum, err_range, err_index, err_proto);
        end
        ioctl_download = 1'b0; cyc(2);
    endtask

    initial begin
        test_reset();
        test_ipl_basic();
        test_cg_range();
        test_bad_index();
        test_flush();
        test_proto_reset();
        test_ram_stream();
        test_random();
        test_hold_no_download();
        test_window_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
